// File: rtl/max7219_cmd_scheduler.sv
// Command scheduler for a daisy-chained MAX7219 string: power-up init, then row/intensity
// refresh passes. Emits one 16-bit word per valid/ready handshake; o_Last marks the latch point.
module max7219_cmd_scheduler #(
  parameter int NUM_DEV        = 1,
  parameter int REFRESH_CYCLES = 1000000
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  input  logic [NUM_DEV*64-1:0] i_FrameBuf,
  input  logic [NUM_DEV*4-1:0]  i_Intensity,
  input  logic                  i_Reinit,
  output logic [15:0]           o_Word,
  output logic                  o_Valid,
  input  logic                  i_Ready,
  output logic                  o_Last,
  output logic                  o_Busy
);

  localparam int DW  = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;
  localparam int RC  = (REFRESH_CYCLES < 1) ? 1 : REFRESH_CYCLES;
  localparam int CW0 = $clog2(RC + 1);
  localparam int CW  = (CW0 < 1) ? 1 : CW0;
  localparam logic [DW-1:0] DEV_TOP   = DW'(NUM_DEV - 1);
  localparam logic [CW-1:0] WAIT_LOAD = CW'(RC - 1);

  typedef enum logic [1:0] {S_INIT, S_ROWS, S_INTEN, S_WAIT} state_t;

  state_t                  state, state_n;
  logic [3:0]              grp, grp_n;
  logic [DW-1:0]           dev, dev_n;
  logic [CW-1:0]           cnt, cnt_n;
  logic                    pend, pend_n;
  logic [NUM_DEV*64-1:0]   sh_fb, sh_fb_n;
  logic [NUM_DEV*4-1:0]    sh_int, sh_int_n;
  logic [15:0]             word_n;
  logic                    valid_n, last_n, busy_n;
  logic                    load, snap, go_init, fire;

  function automatic logic [15:0] make_word(input state_t s, input logic [3:0] g,
                                            input logic [DW-1:0] d,
                                            input logic [NUM_DEV*64-1:0] fb,
                                            input logic [NUM_DEV*4-1:0] it);
    logic [3:0] a;
    logic [7:0] v;
    logic [3:0] inten;
    inten = it[int'(d)*4 +: 4];
    a = 4'hA;
    v = {4'h0, inten};
    case (s)
      S_INIT: begin
        case (g)
          4'd0:    begin a = 4'hC; v = 8'h00; end
          4'd1:    begin a = 4'hF; v = 8'h00; end
          4'd2:    begin a = 4'h9; v = 8'h00; end
          4'd3:    begin a = 4'hB; v = 8'h07; end
          4'd4:    begin a = 4'hA; v = {4'h0, inten}; end
          default: begin a = 4'hC; v = 8'h01; end
        endcase
      end
      S_ROWS: begin
        a = g + 4'd1;
        v = fb[int'(d)*64 + int'(g[2:0])*8 +: 8];
      end
      default: ;
    endcase
    return {4'h0, a, v};
  endfunction

  always_comb begin
    state_n  = state;
    grp_n    = grp;
    dev_n    = dev;
    cnt_n    = cnt;
    pend_n   = pend | i_Reinit;
    sh_fb_n  = sh_fb;
    sh_int_n = sh_int;
    valid_n  = o_Valid;
    busy_n   = o_Busy;
    word_n   = o_Word;
    last_n   = o_Last;
    load     = 1'b0;
    snap     = 1'b0;
    go_init  = 1'b0;
    fire     = o_Valid && i_Ready;

    if (state == S_WAIT) begin
      // a pending reinit preempts the rest of the idle gap
      if (pend) go_init = 1'b1;
      else if (cnt == '0) begin
        state_n = S_ROWS;
        grp_n   = 4'd0;
        dev_n   = DEV_TOP;
        snap    = 1'b1;
        load    = 1'b1;
      end else cnt_n = cnt - 1'b1;
    end else if (!o_Valid) begin
      // first clock after reset: present INIT group 0 from a fresh snapshot
      load = 1'b1;
      snap = 1'b1;
    end else if (fire) begin
      load = 1'b1;
      if (dev != '0) dev_n = dev - 1'b1;
      else begin
        dev_n = DEV_TOP;
        if (pend || i_Reinit) go_init = 1'b1;
        else begin
          case (state)
            S_INIT: begin
              if (grp == 4'd5) begin
                state_n = S_ROWS;
                grp_n   = 4'd0;
                snap    = 1'b1;
                busy_n  = 1'b0;
              end else grp_n = grp + 4'd1;
            end
            S_ROWS: begin
              if (grp == 4'd7) begin
                state_n = S_INTEN;
                grp_n   = 4'd0;
              end else grp_n = grp + 4'd1;
            end
            default: begin
              state_n = S_WAIT;
              cnt_n   = WAIT_LOAD;
              load    = 1'b0;
              valid_n = 1'b0;
            end
          endcase
        end
      end
    end

    if (go_init) begin
      state_n = S_INIT;
      grp_n   = 4'd0;
      dev_n   = DEV_TOP;
      pend_n  = 1'b0;
      snap    = 1'b1;
      busy_n  = 1'b1;
      load    = 1'b1;
    end

    if (snap) begin
      sh_fb_n  = i_FrameBuf;
      sh_int_n = i_Intensity;
    end

    // word is built from the post-edge snapshot so a new pass sees the freshly captured data
    if (load) begin
      valid_n = 1'b1;
      word_n  = make_word(state_n, grp_n, dev_n, sh_fb_n, sh_int_n);
      last_n  = (dev_n == '0);
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state   <= S_INIT;
      grp     <= 4'd0;
      dev     <= DEV_TOP;
      cnt     <= '0;
      pend    <= 1'b0;
      sh_fb   <= '0;
      sh_int  <= '0;
      o_Word  <= 16'h0000;
      o_Valid <= 1'b0;
      o_Last  <= 1'b0;
      o_Busy  <= 1'b1;
    end else begin
      state   <= state_n;
      grp     <= grp_n;
      dev     <= dev_n;
      cnt     <= cnt_n;
      pend    <= pend_n;
      sh_fb   <= sh_fb_n;
      sh_int  <= sh_int_n;
      o_Word  <= word_n;
      o_Valid <= valid_n;
      o_Last  <= last_n;
      o_Busy  <= busy_n;
    end
  end

endmodule

// File: tb/tb_max7219_cmd_scheduler.sv
// Bench for max7219_cmd_scheduler: queue-based word-stream model checked every cycle,
// plus directed scenarios with literal expectations (NUM_DEV=2, REFRESH_CYCLES=5).
module tb_max7219_cmd_scheduler;

  localparam int ND = 2;
  localparam int RC = 5;
  localparam int P_START = 0, P_INIT = 1, P_PASS = 2, P_WAIT = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [ND*64-1:0]  fb = '0;
  logic [ND*4-1:0]   inten = '0;
  logic              reinit = 1'b0;
  logic              ready = 1'b0;
  logic [15:0]       o_word;
  logic              o_valid, o_last, o_busy;

  max7219_cmd_scheduler #(.NUM_DEV(ND), .REFRESH_CYCLES(RC)) dut (
    .i_Clk(clk), .i_Rst(rst_n), .i_FrameBuf(fb), .i_Intensity(inten), .i_Reinit(reinit),
    .o_Word(o_word), .o_Valid(o_valid), .i_Ready(ready), .o_Last(o_last), .o_Busy(o_busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tmo(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // expected word stream: {last, word}
  logic [16:0] q[$];
  int          phase = P_START;
  int          wait_left = 0;
  bit          pend = 0, exp_busy = 1, exp_valid = 0;
  bit          prev_stall = 0;
  logic [15:0] prev_w;
  logic        prev_l;
  logic [15:0] acc_w[$];
  int          acc_c[$];
  int          cyc = 0;

  task automatic push_init(input logic [ND*4-1:0] it);
    logic [3:0] a;
    logic [7:0] v;
    for (int g = 0; g < 6; g++)
      for (int d = ND - 1; d >= 0; d--) begin
        case (g)
          0:       begin a = 4'hC; v = 8'h00; end
          1:       begin a = 4'hF; v = 8'h00; end
          2:       begin a = 4'h9; v = 8'h00; end
          3:       begin a = 4'hB; v = 8'h07; end
          4:       begin a = 4'hA; v = {4'h0, it[d*4 +: 4]}; end
          default: begin a = 4'hC; v = 8'h01; end
        endcase
        q.push_back({d == 0, 4'h0, a, v});
      end
  endtask

  task automatic push_pass(input logic [ND*64-1:0] f, input logic [ND*4-1:0] it);
    for (int r = 0; r < 8; r++)
      for (int d = ND - 1; d >= 0; d--)
        q.push_back({d == 0, 4'h0, 4'(r + 1), f[d*64 + r*8 +: 8]});
    for (int d = ND - 1; d >= 0; d--)
      q.push_back({d == 0, 4'h0, 4'hA, 4'h0, it[d*4 +: 4]});
  endtask

  // compare process: check what the DUT shows now, then predict the next edge
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      chk("rst_valid", o_valid, 0);
      chk("rst_word", o_word, 0);
      chk("rst_last", o_last, 0);
      chk("rst_busy", o_busy, 1);
      q.delete();
      phase = P_START; pend = 0; exp_busy = 1; exp_valid = 0; prev_stall = 0;
    end else begin
      chk("valid", o_valid, exp_valid);
      chk("busy", o_busy, exp_busy);
      if (o_valid) begin
        chk("queue_nonempty", q.size() > 0, 1);
        if (q.size() > 0) begin
          chk("word", o_word, q[0][15:0]);
          chk("last", o_last, q[0][16]);
        end
      end
      if (prev_stall) begin
        chk("stall_valid", o_valid, 1);
        chk("stall_word", o_word, prev_w);
        chk("stall_last", o_last, prev_l);
      end
      prev_stall = o_valid && !ready;
      prev_w = o_word;
      prev_l = o_last;

      case (phase)
        P_START: begin
          pend = pend | reinit;
          push_init(inten);
          phase = P_INIT;
          exp_valid = 1;
        end
        P_WAIT: begin
          if (pend) begin
            pend = 0; push_init(inten); phase = P_INIT; exp_busy = 1; exp_valid = 1;
          end else begin
            pend = pend | reinit;
            if (wait_left == 1) begin
              push_pass(fb, inten); phase = P_PASS; exp_valid = 1;
            end else wait_left--;
          end
        end
        default: begin
          if (o_valid && ready && q.size() > 0) begin
            logic was_last;
            was_last = q[0][16];
            void'(q.pop_front());
            acc_w.push_back(o_word);
            acc_c.push_back(cyc);
            if (was_last && (pend || reinit)) begin
              pend = 0; q.delete(); push_init(inten); phase = P_INIT; exp_busy = 1;
            end else begin
              pend = pend | reinit;
              if (q.size() == 0) begin
                if (phase == P_INIT) begin
                  push_pass(fb, inten); phase = P_PASS; exp_busy = 0;
                end else begin
                  phase = P_WAIT; wait_left = RC; exp_valid = 0;
                end
              end
            end
          end else pend = pend | reinit;
        end
      endcase
    end
  end

  logic [15:0] exp1 [31] = '{
    16'h0C00, 16'h0C00, 16'h0F00, 16'h0F00, 16'h0900, 16'h0900, 16'h0B07, 16'h0B07,
    16'h0A03, 16'h0A07, 16'h0C01, 16'h0C01,
    16'h0100, 16'h0102, 16'h02A5, 16'h0200, 16'h0300, 16'h0300, 16'h0400, 16'h0400,
    16'h0500, 16'h0500, 16'h0600, 16'h0600, 16'h0700, 16'h0700, 16'h0800, 16'h0800,
    16'h0A03, 16'h0A07, 16'h0100
  };

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int n;
    fb[1] = 1'b1;
    fb[64+8 +: 8] = 8'hA5;
    inten = 8'h37;
    ready = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // init + one refresh pass + idle gap, ready held high
    n = 0;
    while (acc_w.size() < 31 && n < 200) begin step(); n++; end
    if (n >= 200) tmo("init_pass_collect");
    else begin
      for (int i = 0; i < 31; i++) chk($sformatf("lit_word_%0d", i), acc_w[i], exp1[i]);
      chk("wait_gap", acc_c[30] - acc_c[29] - 1, RC);
    end

    // random backpressure
    repeat (150) begin step(); ready = ($urandom_range(0, 99) < 60); end
    ready = 1'b1;

    // snapshot coherence
    n = 0;
    while (!(o_valid && o_word[11:8] == 4'h3) && n < 300) begin step(); n++; end
    if (n >= 300) tmo("snap_find_row3");
    ready = 1'b0;
    fb[7*8 +: 8] = 8'h81;
    repeat (2) step();
    ready = 1'b1;
    n = 0;
    while (!(o_valid && o_last && o_word[11:8] == 4'h8) && n < 300) begin step(); n++; end
    if (n >= 300) tmo("snap_old_find"); else chk("snap_old", o_word, 16'h0800);
    step();
    n = 0;
    while (!(o_valid && o_last && o_word[11:8] == 4'h8) && n < 300) begin step(); n++; end
    if (n >= 300) tmo("snap_new_find"); else chk("snap_new", o_word, 16'h0881);

    // reinit while the device-1 row-4 word is stalled
    n = 0;
    while (!(o_valid && o_word == 16'h0400 && !o_last) && n < 300) begin step(); n++; end
    if (n >= 300) tmo("rein_find");
    ready = 1'b0;
    step(); reinit = 1'b1;
    step(); reinit = 1'b0;
    step(); chk("rein_stall_word", o_word, 16'h0400);
    ready = 1'b1;
    n = 0;
    while (!(o_valid && o_last && o_word[11:8] == 4'h4) && n < 50) begin step(); n++; end
    if (n >= 50) tmo("rein_last_find");
    step();
    chk("rein_word", o_word, 16'h0C00);
    chk("rein_busy", o_busy, 1);

    // reinit request inside INIT
    repeat (3) step();
    reinit = 1'b1; step(); reinit = 1'b0;
    n = 0;
    while (o_busy && n < 200) begin step(); n++; end
    if (n >= 200) tmo("init_done");

    // reinit coinciding with an o_Last acceptance
    n = 0;
    while (!(o_valid && o_last && o_word[11:8] == 4'h5) && n < 300) begin step(); n++; end
    if (n >= 300) tmo("sim_find");
    reinit = 1'b1; step(); reinit = 1'b0;
    chk("sim_word", o_word, 16'h0C00);
    chk("sim_busy", o_busy, 1);

    // reinit during the idle gap
    n = 0;
    while (!(o_valid && o_last && o_word[11:8] == 4'hA && !o_busy) && n < 300) begin step(); n++; end
    if (n >= 300) tmo("wait_find");
    step(); chk("wait_idle", o_valid, 0);
    step(); reinit = 1'b1;
    step(); reinit = 1'b0;
    step(); chk("wait_rein", {o_valid, o_word}, {1'b1, 16'h0C00});

    // reset in the middle of the INTEN group
    n = 0;
    while (!(o_valid && o_word[11:8] == 4'hA && !o_busy) && n < 300) begin step(); n++; end
    if (n >= 300) tmo("rst_find");
    #1 rst_n = 1'b0;
    #1 chk("rst_async_valid", o_valid, 0);
    chk("rst_async_busy", o_busy, 1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1 chk("rst_first_word", {o_valid, o_word}, {1'b1, 16'h0C00});

    repeat (200) begin step(); ready = ($urandom_range(0, 99) < 70); end
    ready = 1'b1;
    repeat (5) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
